// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Memory-stage hit wins over writeback-stage hit.
  function automatic fwd_sel_e fwd_select(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_M;
    if (hit_w) return FWD_W;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for long-latency writes plus an outstanding-op count.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int MAX_PEND = 4,
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_i,
  input  logic [ADDR_W-1:0]      issue_rd_i,
  input  logic                   done_i,
  input  logic [ADDR_W-1:0]      done_rd_i,
  output logic [2**ADDR_W-1:0]   pending_o,
  output logic [PW-1:0]          count_o,
  output logic                   full_o
);

  logic [2**ADDR_W-1:0] pending_q, pending_d;
  logic [PW-1:0]        count_q, count_d;
  logic                 do_issue, do_done, inc, dec;

  assign full_o   = (count_q == PW'(MAX_PEND));
  assign do_issue = issue_i && (issue_rd_i != '0) && !full_o;
  assign do_done  = done_i && pending_q[done_rd_i];
  // A re-issue to a register that is already pending (or completing in the same
  // cycle) keeps its single bit, so the count stays equal to the number of set bits.
  assign inc      = do_issue && !pending_q[issue_rd_i];
  assign dec      = do_done && !(do_issue && (issue_rd_i == done_rd_i));

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (do_done)  pending_d[done_rd_i]  = 1'b0;
    if (do_issue) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
    if (inc && !dec)      count_d = count_q + PW'(1);
    else if (dec && !inc) count_d = count_q - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: forwarding selects, load-use and scoreboard
// stalls, branch flushes, and a stall-cycle watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 8,
  parameter int WD_LIMIT = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              Rs1D,
  input  logic [ADDR_W-1:0]              Rs2D,
  input  logic [ADDR_W-1:0]              RdD,
  input  logic                           LongOpD,
  input  logic [ADDR_W-1:0]              Rs1E,
  input  logic [ADDR_W-1:0]              Rs2E,
  input  logic [ADDR_W-1:0]              RdE,
  input  logic [1:0]                     ResultSrcE,
  input  logic                           PCSrcE,
  input  logic                           LongIssueE,
  input  logic [ADDR_W-1:0]              RdM,
  input  logic                           RegWriteM,
  input  logic [ADDR_W-1:0]              RdW,
  input  logic                           RegWriteW,
  input  logic                           LongDoneW,
  input  logic [ADDR_W-1:0]              LongRdW,
  output logic                           StallF,
  output logic                           StallD,
  output logic                           FlushD,
  output logic                           FlushE,
  output logic [1:0]                     ForwardAE,
  output logic [1:0]                     ForwardBE,
  output logic [$clog2(MAX_PEND+1)-1:0]  PendCount,
  output logic [CNT_W-1:0]               StallCycles,
  output logic                           Watchdog
);

  localparam int          PW         = $clog2(MAX_PEND + 1);
  localparam logic [31:0] WD_LIMIT_U = WD_LIMIT;

  logic [2**ADDR_W-1:0] pending;
  logic                 sb_full;
  logic                 lw_stall, sb_stall, hazard_stall;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic                 watchdog_q, watchdog_d;

  hazard_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND),
    .PW       (PW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (LongIssueE),
    .issue_rd_i (RdE),
    .done_i     (LongDoneW),
    .done_rd_i  (LongRdW),
    .pending_o  (pending),
    .count_o    (PendCount),
    .full_o     (sb_full)
  );

  assign ForwardAE = fwd_select((Rs1E != '0) && RegWriteM && (Rs1E == RdM),
                                (Rs1E != '0) && RegWriteW && (Rs1E == RdW));
  assign ForwardBE = fwd_select((Rs2E != '0) && RegWriteM && (Rs2E == RdM),
                                (Rs2E != '0) && RegWriteW && (Rs2E == RdW));

  assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  assign sb_stall = ((Rs1D != '0) && pending[Rs1D]) ||
                    ((Rs2D != '0) && pending[Rs2D]) ||
                    (LongOpD && pending[RdD]) ||
                    (LongOpD && sb_full);

  assign hazard_stall = lw_stall || sb_stall;

  // A taken branch discards the decode and execute contents, so stalling is moot.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = hazard_stall;
      StallD = hazard_stall;
      FlushE = hazard_stall;
    end
  end

  always_comb begin
    stall_cycles_d = '0;
    if (StallD) begin
      if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      else                      stall_cycles_d = stall_cycles_q;
    end
    watchdog_d = watchdog_q || (32'(stall_cycles_d) == WD_LIMIT_U);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      watchdog_q     <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      watchdog_q     <= watchdog_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign Watchdog    = watchdog_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
  logic       LongOpD, PCSrcE, LongIssueE, RegWriteM, RegWriteW, LongDoneW;
  logic [1:0] ResultSrcE;
  logic       StallF, StallD, FlushD, FlushE, Watchdog;
  logic [1:0] ForwardAE, ForwardBE;
  logic [2:0] PendCount;
  logic [7:0] StallCycles;

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_ctrl #(.ADDR_W(5), .MAX_PEND(4), .CNT_W(8), .WD_LIMIT(200)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .LongIssueE(LongIssueE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .LongDoneW(LongDoneW), .LongRdW(LongRdW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PendCount(PendCount), .StallCycles(StallCycles), .Watchdog(Watchdog)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; RdD = '0; LongOpD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; LongIssueE = 1'b0;
    RdM = '0; RegWriteM = 1'b0; RdW = '0; RegWriteW = 1'b0;
    LongDoneW = 1'b0; LongRdW = '0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    LongIssueE = 1'b1; RdE = rd;
    tick();
    LongIssueE = 1'b0; RdE = '0;
  endtask

  task automatic done(input logic [4:0] rd);
    LongDoneW = 1'b1; LongRdW = rd;
    tick();
    LongDoneW = 1'b0; LongRdW = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    tests_run++; if (PendCount !== 3'd0) begin tests_failed++; $display("FAIL reset_pend got=%0d exp=0", PendCount); end
    tests_run++; if (StallCycles !== 8'd0) begin tests_failed++; $display("FAIL reset_stallcycles got=%0d exp=0", StallCycles); end
    tests_run++; if (Watchdog !== 1'b0) begin tests_failed++; $display("FAIL reset_watchdog got=%b exp=0", Watchdog); end
    tests_run++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctrl got=%b exp=0000", {StallF, StallD, FlushD, FlushE}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
    #1;
    tests_run++; if (ForwardAE !== 2'b10) begin tests_failed++; $display("FAIL fwd_prio got=%b exp=10", ForwardAE); end
    RegWriteM = 1'b0;
    #1;
    tests_run++; if (ForwardAE !== 2'b01) begin tests_failed++; $display("FAIL fwd_w got=%b exp=01", ForwardAE); end
    RegWriteM = 1'b1; Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
    #1;
    tests_run++; if (ForwardAE !== 2'b00) begin tests_failed++; $display("FAIL fwd_x0 got=%b exp=00", ForwardAE); end
    Rs2E = 5'd6; RdM = 5'd6; RegWriteM = 1'b0; RdW = 5'd6; RegWriteW = 1'b1;
    #1;
    tests_run++; if (ForwardBE !== 2'b01) begin tests_failed++; $display("FAIL fwdb_w got=%b exp=01", ForwardBE); end
    RegWriteM = 1'b1;
    #1;
    tests_run++; if (ForwardBE !== 2'b10) begin tests_failed++; $display("FAIL fwdb_m got=%b exp=10", ForwardBE); end
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    tests_run++; if (ForwardBE !== 2'b00) begin tests_failed++; $display("FAIL fwdb_none got=%b exp=00", ForwardBE); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    tests_run++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin tests_failed++; $display("FAIL lw_stall got=%b exp=1101", {StallF, StallD, FlushD, FlushE}); end
    tick();
    tests_run++; if (StallCycles !== 8'd1) begin tests_failed++; $display("FAIL lw_cycles got=%0d exp=1", StallCycles); end
    // Bubble now sits in execute.
    ResultSrcE = 2'b00; RdE = 5'd0;
    #1;
    tests_run++; if ({StallF, StallD, FlushE} !== 3'b000) begin tests_failed++; $display("FAIL lw_release got=%b exp=000", {StallF, StallD, FlushE}); end
    tick();
    tests_run++; if (StallCycles !== 8'd0) begin tests_failed++; $display("FAIL lw_cycles_clr got=%0d exp=0", StallCycles); end
    ResultSrcE = 2'b01; RdE = 5'd0; Rs2D = 5'd0;
    #1;
    tests_run++; if ({StallF, StallD, FlushE} !== 3'b000) begin tests_failed++; $display("FAIL lw_x0 got=%b exp=000", {StallF, StallD, FlushE}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    LongIssueE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    #1;
    tests_run++; if (StallD !== 1'b0) begin tests_failed++; $display("FAIL sb_no_bypass got=%b exp=0", StallD); end
    tick();
    LongIssueE = 1'b0; RdE = '0;
    #1;
    tests_run++; if (PendCount !== 3'd1) begin tests_failed++; $display("FAIL sb_pend1 got=%0d exp=1", PendCount); end
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL sb_stall got=%b exp=1", StallD); end
    tick();
    LongDoneW = 1'b1; LongRdW = 5'd9;
    #1;
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL sb_stall_done_cycle got=%b exp=1", StallD); end
    tick();
    LongDoneW = 1'b0; LongRdW = '0;
    #1;
    tests_run++; if (PendCount !== 3'd0) begin tests_failed++; $display("FAIL sb_pend0 got=%0d exp=0", PendCount); end
    tests_run++; if (StallD !== 1'b0) begin tests_failed++; $display("FAIL sb_release got=%b exp=0", StallD); end
    clear_inputs();
    tick();
  endtask

  task automatic test_full();
    clear_inputs();
    for (int r = 1; r <= 4; r++) issue(5'(r));
    tests_run++; if (PendCount !== 3'd4) begin tests_failed++; $display("FAIL full_pend got=%0d exp=4", PendCount); end
    LongOpD = 1'b1; RdD = 5'd10;
    #1;
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL full_stall got=%b exp=1", StallD); end
    issue(5'd5);
    tests_run++; if (PendCount !== 3'd4) begin tests_failed++; $display("FAIL full_overflow got=%0d exp=4", PendCount); end
    done(5'd1);
    #1;
    tests_run++; if (PendCount !== 3'd3) begin tests_failed++; $display("FAIL full_done1 got=%0d exp=3", PendCount); end
    tests_run++; if (StallD !== 1'b0) begin tests_failed++; $display("FAIL full_release got=%b exp=0", StallD); end
    LongOpD = 1'b0; Rs1D = 5'd5;
    #1;
    tests_run++; if (StallD !== 1'b0) begin tests_failed++; $display("FAIL full_ignored_issue got=%b exp=0", StallD); end
    Rs1D = 5'd0; LongOpD = 1'b1; RdD = 5'd2;
    #1;
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL waw_stall got=%b exp=1", StallD); end
    LongOpD = 1'b0; RdD = '0;
    // Issue x5 while x2 completes.
    LongIssueE = 1'b1; RdE = 5'd5; LongDoneW = 1'b1; LongRdW = 5'd2;
    tick();
    tests_run++; if (PendCount !== 3'd3) begin tests_failed++; $display("FAIL swap_pend got=%0d exp=3", PendCount); end
    // Issue and completion of the same register x3.
    RdE = 5'd3; LongRdW = 5'd3;
    tick();
    LongIssueE = 1'b0; RdE = '0; LongDoneW = 1'b0; LongRdW = '0;
    Rs1D = 5'd3;
    #1;
    tests_run++; if (PendCount !== 3'd3) begin tests_failed++; $display("FAIL same_pend got=%0d exp=3", PendCount); end
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL same_bit_kept got=%b exp=1", StallD); end
    Rs1D = 5'd0;
    done(5'd1);
    tests_run++; if (PendCount !== 3'd3) begin tests_failed++; $display("FAIL underflow got=%0d exp=3", PendCount); end
    done(5'd3); done(5'd4); done(5'd5);
    tests_run++; if (PendCount !== 3'd0) begin tests_failed++; $display("FAIL drain got=%0d exp=0", PendCount); end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    #1;
    tests_run++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin tests_failed++; $display("FAIL branch_override got=%b exp=0011", {StallF, StallD, FlushD, FlushE}); end
    PCSrcE = 1'b0;
    #1;
    tests_run++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin tests_failed++; $display("FAIL branch_off got=%b exp=1101", {StallF, StallD, FlushD, FlushE}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    clear_inputs();
    tick();
    issue(5'd3);
    Rs1D = 5'd3;
    #1;
    tests_run++; if (StallD !== 1'b1) begin tests_failed++; $display("FAIL wd_stall got=%b exp=1", StallD); end
    repeat (199) tick();
    tests_run++; if (StallCycles !== 8'd199) begin tests_failed++; $display("FAIL wd_cnt199 got=%0d exp=199", StallCycles); end
    tests_run++; if (Watchdog !== 1'b0) begin tests_failed++; $display("FAIL wd_early got=%b exp=0", Watchdog); end
    tick();
    tests_run++; if (StallCycles !== 8'd200) begin tests_failed++; $display("FAIL wd_cnt200 got=%0d exp=200", StallCycles); end
    tests_run++; if (Watchdog !== 1'b1) begin tests_failed++; $display("FAIL wd_set got=%b exp=1", Watchdog); end
    repeat (60) tick();
    tests_run++; if (StallCycles !== 8'd255) begin tests_failed++; $display("FAIL wd_saturate got=%0d exp=255", StallCycles); end
    Rs1D = 5'd0;
    tick();
    tests_run++; if (StallCycles !== 8'd0) begin tests_failed++; $display("FAIL wd_cnt_clr got=%0d exp=0", StallCycles); end
    tests_run++; if (Watchdog !== 1'b1) begin tests_failed++; $display("FAIL wd_sticky got=%b exp=1", Watchdog); end
    Rs1D = 5'd3;
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (PendCount !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_pend got=%0d exp=0", PendCount); end
    tests_run++; if (Watchdog !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_wd got=%b exp=0", Watchdog); end
    tests_run++; if (StallCycles !== 8'd0) begin tests_failed++; $display("FAIL rst_mid_cnt got=%0d exp=0", StallCycles); end
    tests_run++; if (StallD !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_stall got=%b exp=0", StallD); end
    #1;
    rst = 1'b0;
    done(5'd3);
    tests_run++; if (PendCount !== 3'd0) begin tests_failed++; $display("FAIL rst_stale_done got=%0d exp=0", PendCount); end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_full();
    test_branch();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
